// File: rtl/program_counter_pkg.sv
// Shared constants and control decoding for the program counter.
// Holds the default bus width, default return-stack depth and reset vector.
package program_counter_pkg;

    localparam int DEFAULT_BUS_WIDTH   = 16;
    localparam int DEFAULT_STACK_DEPTH = 8;
    localparam int RESET_VECTOR        = 0;

    typedef enum logic [2:0] {
        OP_HOLD,
        OP_INC,
        OP_LOAD,
        OP_CALL,
        OP_RET
    } pc_op_e;

    // Strict priority: ret > call > load > inc > hold (reset is handled by the registers).
    function automatic pc_op_e decode_op(input logic ret, input logic call,
                                         input logic load, input logic inc);
        if (ret)       return OP_RET;
        else if (call) return OP_CALL;
        else if (load) return OP_LOAD;
        else if (inc)  return OP_INC;
        else           return OP_HOLD;
    endfunction

endpackage

// File: rtl/d_flipflop.sv
// Shared register primitive: WIDTH-bit D register with synchronous reset and load enable.
module d_flipflop #(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
        if (reset)
            q <= RESET_VALUE;
        else if (load)
            q <= d;
    end

endmodule

// File: rtl/return_stack.sv
// LIFO of return addresses; built only when PC_CALL_STACK_EN is defined.
// Pushes while full and pops while empty are dropped; pop wins if both are requested.
`ifdef PC_CALL_STACK_EN
module return_stack #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         push_data,
    output logic [WIDTH-1:0]         top,
    output logic [$clog2(DEPTH):0]   depth,
    output logic                     empty,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      top_slot;

    assign empty    = (depth == '0);
    assign full     = (depth == (AW + 1)'(DEPTH));
    assign top_slot = depth - 1'b1;
    assign top      = mem[top_slot[AW-1:0]];

    always_ff @(posedge clock) begin
        if (reset)
            depth <= '0;
        else if (pop && !empty)
            depth <= depth - 1'b1;
        else if (push && !full)
            depth <= depth + 1'b1;
    end

    // NOTE: entries are not reset; depth alone decides what is readable, so storage can stay plain RAM.
    always_ff @(posedge clock) begin
        if (!reset && push && !pop && !full)
            mem[depth[AW-1:0]] <= push_data;
    end

endmodule
`endif

// File: rtl/program_counter.sv
// Program counter with jump, increment, call and return; the return stack and its
// status flags exist only when PC_CALL_STACK_EN is defined (otherwise call acts as load).
module program_counter
    import program_counter_pkg::*;
#(
    parameter int BUS_WIDTH   = DEFAULT_BUS_WIDTH,
    parameter int STACK_DEPTH = DEFAULT_STACK_DEPTH
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [BUS_WIDTH-1:0] in,
    input  logic                 load,
    input  logic                 inc,
    input  logic                 call,
    input  logic                 ret,
    output logic [BUS_WIDTH-1:0] out,
    output logic                 empty,
    output logic                 full,
    output logic                 overflow,
    output logic                 underflow
);

    if (STACK_DEPTH < 2 || (STACK_DEPTH & (STACK_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("program_counter: STACK_DEPTH must be a power of two and at least 2");
    end

    pc_op_e               op;
    logic [BUS_WIDTH-1:0] inc_addr;
    logic [BUS_WIDTH-1:0] next_addr;
    logic                 stack_empty;
    logic                 stack_full;
    logic [BUS_WIDTH-1:0] stack_top;

    assign inc_addr = out + BUS_WIDTH'(1);

`ifdef PC_CALL_STACK_EN
    logic [$clog2(STACK_DEPTH):0] unused_depth;
    logic                         overflow_q;
    logic                         underflow_q;

    assign op = decode_op(ret, call, load, inc);

    return_stack #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (BUS_WIDTH)
    ) u_return_stack (
        .clock     (clock),
        .reset     (reset),
        .push      (op == OP_CALL),
        .pop       (op == OP_RET),
        .push_data (inc_addr),
        .top       (stack_top),
        .depth     (unused_depth),
        .empty     (stack_empty),
        .full      (stack_full)
    );

    // Sticky error flags: they record misuse but never block later operations.
    always_ff @(posedge clock) begin
        if (reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_q  | ((op == OP_CALL) && stack_full);
            underflow_q <= underflow_q | ((op == OP_RET)  && stack_empty);
        end
    end

    assign empty     = stack_empty;
    assign full      = stack_full;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`else
    logic unused_ret;

    assign unused_ret  = ret;
    assign op          = decode_op(1'b0, call, load, inc);
    assign stack_empty = 1'b1;
    assign stack_full  = 1'b0;
    assign stack_top   = out;

    assign empty     = 1'b1;
    assign full      = 1'b0;
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

    always_comb begin
        // NOTE: default first so every path assigns next_addr and no latch is inferred.
        next_addr = out;
        unique case (op)
            OP_RET:           next_addr = stack_empty ? out : stack_top;
            OP_CALL, OP_LOAD: next_addr = in;
            OP_INC:           next_addr = inc_addr;
            default:          next_addr = out;
        endcase
    end

    d_flipflop #(
        .WIDTH       (BUS_WIDTH),
        .RESET_VALUE (BUS_WIDTH'(RESET_VECTOR))
    ) u_out_reg (
        .clock (clock),
        .reset (reset),
        .load  (1'b1),
        .d     (next_addr),
        .q     (out)
    );

endmodule
